// File: rtl/interrupt_acknowledge_sequencer_if.sv
// CPU-side bundle of the interrupt acknowledge sequencer: INT, INTA and the vector data bus.
// The sequencer drives the slave modport; the CPU/bus model uses master.
interface interrupt_acknowledge_sequencer_if;
    logic       interrupt;
    logic       interrupt_acknowledge_n;
    logic [7:0] data_out;
    logic       data_out_enable;

    modport master (
        input  interrupt,
        input  data_out,
        input  data_out_enable,
        output interrupt_acknowledge_n
    );

    modport slave (
        output interrupt,
        output data_out,
        output data_out_enable,
        input  interrupt_acknowledge_n
    );
endinterface

// File: rtl/interrupt_acknowledge_sequencer.sv
// 8259A interrupt-acknowledge sequencer: rotating priority resolution, ISR ownership,
// two-pulse 8086 INTA handshake and EOI servicing. Define AUTO_EOI_EN for automatic EOI.
module interrupt_acknowledge_sequencer (
    input  logic                                 clock,
    input  logic                                 reset,
    interrupt_acknowledge_sequencer_if.slave     cpu_bus,
    input  logic [7:0]                           interrupt_request,
    input  logic [2:0]                           priority_rotate,
    input  logic                                 special_mask_mode,
    input  logic [7:0]                           interrupt_special_mask,
    input  logic [4:0]                           vector_base,
`ifdef AUTO_EOI_EN
    input  logic                                 auto_eoi_config,
`endif
    input  logic                                 eoi_strobe,
    input  logic                                 eoi_specific,
    input  logic [2:0]                           eoi_level,
    output logic [7:0]                           in_service_register,
    output logic [7:0]                           highest_level_in_service,
    output logic [7:0]                           clear_interrupt_request
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACK1  = 2'd1;
    localparam logic [1:0] WAIT2 = 2'd2;
    localparam logic [1:0] ACK2  = 2'd3;

    logic [1:0] state;
    logic       inta_d1;
    logic       inta_d2;
    logic       inta_fall;
    logic       inta_rise;
    logic [2:0] acked_level;
`ifdef AUTO_EOI_EN
    logic       acked_spurious;
`endif

    logic [7:0] effective_isr;
    logic [2:0] scan_level;
    logic       winner_valid;
    logic [2:0] winner_level;
    logic [2:0] winner_rank;
    logic       isr_valid;
    logic [2:0] isr_level;
    logic [2:0] isr_rank;
    logic       interrupt_allowed;
    logic [7:0] isr_next;

    assign inta_fall = inta_d2 & ~inta_d1;
    assign inta_rise = ~inta_d2 & inta_d1;

    // Scan from lowest to highest priority so the last hit is the lowest rank.
    always_comb begin
        winner_valid  = 1'b0;
        winner_level  = 3'd0;
        winner_rank   = 3'd0;
        isr_valid     = 1'b0;
        isr_level     = 3'd0;
        isr_rank      = 3'd0;
        scan_level    = 3'd0;
        effective_isr = special_mask_mode ? (in_service_register & ~interrupt_special_mask)
                                          : in_service_register;
        for (int i = 7; i >= 0; i--) begin
            scan_level = priority_rotate + 3'(i) + 3'd1;
            if (interrupt_request[scan_level]) begin
                winner_valid = 1'b1;
                winner_level = scan_level;
                winner_rank  = 3'(i);
            end
            if (effective_isr[scan_level]) begin
                isr_valid = 1'b1;
                isr_level = scan_level;
                isr_rank  = 3'(i);
            end
        end
    end

    assign highest_level_in_service = isr_valid ? (8'b1 << isr_level) : 8'h00;
    assign interrupt_allowed = winner_valid & (~isr_valid | (winner_rank < isr_rank));

    // EOI clears go first so a same-cycle acknowledge of the same level keeps its bit set.
    always_comb begin
        isr_next = in_service_register;
        if (eoi_strobe) begin
            if (eoi_specific) begin
                isr_next[eoi_level] = 1'b0;
            end else begin
                isr_next = isr_next & ~highest_level_in_service;
            end
        end
`ifdef AUTO_EOI_EN
        if (state == ACK2 && inta_rise && auto_eoi_config && !acked_spurious) begin
            isr_next[acked_level] = 1'b0;
        end
`endif
        if (state == IDLE && inta_fall && winner_valid) begin
            isr_next[winner_level] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                   <= IDLE;
            inta_d1                 <= 1'b1;
            inta_d2                 <= 1'b1;
            acked_level             <= 3'd0;
`ifdef AUTO_EOI_EN
            acked_spurious          <= 1'b0;
`endif
            in_service_register     <= 8'h00;
            clear_interrupt_request <= 8'h00;
            cpu_bus.interrupt       <= 1'b0;
            cpu_bus.data_out        <= 8'h00;
            cpu_bus.data_out_enable <= 1'b0;
        end else begin
            inta_d1                 <= cpu_bus.interrupt_acknowledge_n;
            inta_d2                 <= inta_d1;
            in_service_register     <= isr_next;
            clear_interrupt_request <= 8'h00;
            case (state)
                IDLE: begin
                    cpu_bus.interrupt <= interrupt_allowed;
                    if (inta_fall) begin
                        cpu_bus.interrupt <= 1'b0;
                        state             <= ACK1;
                        // No winner at the first pulse means a spurious cycle answered as level 7.
                        if (winner_valid) begin
                            acked_level             <= winner_level;
                            clear_interrupt_request <= 8'b1 << winner_level;
`ifdef AUTO_EOI_EN
                            acked_spurious          <= 1'b0;
`endif
                        end else begin
                            acked_level             <= 3'd7;
`ifdef AUTO_EOI_EN
                            acked_spurious          <= 1'b1;
`endif
                        end
                    end
                end
                ACK1: begin
                    cpu_bus.interrupt <= 1'b0;
                    if (inta_rise) begin
                        state <= WAIT2;
                    end
                end
                WAIT2: begin
                    cpu_bus.interrupt <= 1'b0;
                    if (inta_fall) begin
                        cpu_bus.data_out        <= {vector_base, acked_level};
                        cpu_bus.data_out_enable <= 1'b1;
                        state                   <= ACK2;
                    end
                end
                ACK2: begin
                    cpu_bus.interrupt <= 1'b0;
                    if (inta_rise) begin
                        cpu_bus.data_out_enable <= 1'b0;
                        state                   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Scenario bench for interrupt_acknowledge_sequencer; expected vectors are queued when an
// INTA cycle starts and popped when the sequencer enables its vector. Honours AUTO_EOI_EN.
module tb_interrupt_acknowledge_sequencer;

    logic       clock;
    logic       reset;
    logic [7:0] interrupt_request;
    logic [2:0] priority_rotate;
    logic       special_mask_mode;
    logic [7:0] interrupt_special_mask;
    logic [4:0] vector_base;
`ifdef AUTO_EOI_EN
    logic       auto_eoi_config;
`endif
    logic       eoi_strobe;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [7:0] clear_interrupt_request;

    int vectors;
    int miscompares;
    logic [7:0] vector_queue[$];

    interrupt_acknowledge_sequencer_if cpu_bus ();

    interrupt_acknowledge_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .cpu_bus                  (cpu_bus.slave),
        .interrupt_request        (interrupt_request),
        .priority_rotate          (priority_rotate),
        .special_mask_mode        (special_mask_mode),
        .interrupt_special_mask   (interrupt_special_mask),
        .vector_base              (vector_base),
`ifdef AUTO_EOI_EN
        .auto_eoi_config          (auto_eoi_config),
`endif
        .eoi_strobe               (eoi_strobe),
        .eoi_specific             (eoi_specific),
        .eoi_level                (eoi_level),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service),
        .clear_interrupt_request  (clear_interrupt_request)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset;
        reset                           = 1'b1;
        cpu_bus.interrupt_acknowledge_n = 1'b1;
        interrupt_request               = 8'h00;
        priority_rotate                 = 3'd7;
        special_mask_mode               = 1'b0;
        interrupt_special_mask          = 8'h00;
        vector_base                     = 5'h08;
`ifdef AUTO_EOI_EN
        auto_eoi_config                 = 1'b0;
`endif
        eoi_strobe                      = 1'b0;
        eoi_specific                    = 1'b0;
        eoi_level                       = 3'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Full two-pulse INTA cycle; optionally fires a specific EOI in the first-edge detect cycle.
    task automatic run_inta(input string name, input logic [7:0] exp_isr, input logic [7:0] exp_clear,
                            input logic [7:0] exp_vec, input bit eoi_same, input logic [2:0] eoi_lvl);
        logic [7:0] expected;
        bit seen;
        seen = 1'b0;
        vector_queue.push_back(exp_vec);
        cpu_bus.interrupt_acknowledge_n = 1'b0;
        tick();
        if (eoi_same) begin
            eoi_strobe   = 1'b1;
            eoi_specific = 1'b1;
            eoi_level    = eoi_lvl;
        end
        tick();
        eoi_strobe = 1'b0;
        check8({name, " clear pulse"}, clear_interrupt_request, exp_clear);
        check8({name, " isr after inta1"}, in_service_register, exp_isr);
        check8({name, " int low in ack"}, {7'd0, cpu_bus.interrupt}, 8'h00);
        tick();
        check8({name, " clear one cycle"}, clear_interrupt_request, 8'h00);
        cpu_bus.interrupt_acknowledge_n = 1'b1;
        tick();
        tick();
        cpu_bus.interrupt_acknowledge_n = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (cpu_bus.data_out_enable === 1'b1) seen = 1'b1;
        end
        expected = vector_queue.pop_front();
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL %s vector timeout got enable=%b expected 1", name, cpu_bus.data_out_enable);
        end else if (cpu_bus.data_out !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s vector got %h expected %h", name, cpu_bus.data_out, expected);
        end
        cpu_bus.interrupt_acknowledge_n = 1'b1;
        tick();
        tick();
        check8({name, " enable off"}, {7'd0, cpu_bus.data_out_enable}, 8'h00);
        check8({name, " data holds"}, cpu_bus.data_out, exp_vec);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cpu_bus.interrupt_acknowledge_n = 1'b1;
        interrupt_request = 8'hFF;
        tick();
        check8("reset int", {7'd0, cpu_bus.interrupt}, 8'h00);
        check8("reset isr", in_service_register, 8'h00);
        check8("reset clear", clear_interrupt_request, 8'h00);
        check8("reset data", cpu_bus.data_out, 8'h00);
        check8("reset enable", {7'd0, cpu_bus.data_out_enable}, 8'h00);
        check8("reset hlis", highest_level_in_service, 8'h00);
        do_reset();
    endtask

    task automatic test_basic;
        do_reset();
        interrupt_request = 8'h24;
        tick();
        check8("basic int", {7'd0, cpu_bus.interrupt}, 8'h01);
        run_inta("basic", 8'h04, 8'h04, 8'h42, 1'b0, 3'd0);
        interrupt_request = 8'h20;
        tick();
        tick();
        check8("basic nested int", {7'd0, cpu_bus.interrupt}, 8'h00);
        check8("basic hlis", highest_level_in_service, 8'h04);
    endtask

    task automatic test_nesting;
        do_reset();
        interrupt_request = 8'h02;
        tick();
        run_inta("nest", 8'h02, 8'h02, 8'h41, 1'b0, 3'd0);
        interrupt_request = 8'h08;
        tick();
        tick();
        check8("nest blocked", {7'd0, cpu_bus.interrupt}, 8'h00);
        special_mask_mode      = 1'b1;
        interrupt_special_mask = 8'h02;
        tick();
        check8("nest smm int", {7'd0, cpu_bus.interrupt}, 8'h01);
        check8("nest smm hlis", highest_level_in_service, 8'h00);
    endtask

    task automatic test_rotation;
        do_reset();
        priority_rotate   = 3'd2;
        interrupt_request = 8'h09;
        tick();
        check8("rot int", {7'd0, cpu_bus.interrupt}, 8'h01);
        run_inta("rot", 8'h08, 8'h08, 8'h43, 1'b0, 3'd0);
    endtask

    task automatic test_spurious;
        do_reset();
        interrupt_request = 8'h10;
        tick();
        check8("spur int", {7'd0, cpu_bus.interrupt}, 8'h01);
        interrupt_request = 8'h00;
        run_inta("spur", 8'h00, 8'h00, 8'h47, 1'b0, 3'd0);
        check8("spur isr", in_service_register, 8'h00);
    endtask

    task automatic test_eoi;
        do_reset();
        interrupt_request = 8'h08;
        tick();
        run_inta("eoi ir3", 8'h08, 8'h08, 8'h43, 1'b0, 3'd0);
        interrupt_request = 8'h02;
        tick();
        tick();
        check8("eoi preempt int", {7'd0, cpu_bus.interrupt}, 8'h01);
        run_inta("eoi ir1", 8'h0A, 8'h02, 8'h41, 1'b0, 3'd0);
        interrupt_request = 8'h00;
        check8("eoi hlis", highest_level_in_service, 8'h02);
        eoi_strobe = 1'b1; eoi_specific = 1'b0;
        tick();
        eoi_strobe = 1'b0;
        check8("eoi nonspecific", in_service_register, 8'h08);
        eoi_strobe = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
        tick();
        eoi_strobe = 1'b0;
        check8("eoi specific", in_service_register, 8'h00);
        eoi_strobe = 1'b1; eoi_specific = 1'b0;
        tick();
        eoi_strobe = 1'b0;
        check8("eoi empty", in_service_register, 8'h00);
    endtask

    task automatic test_simultaneous;
        do_reset();
        interrupt_request = 8'h04;
        tick();
        run_inta("simul", 8'h04, 8'h04, 8'h42, 1'b1, 3'd2);
    endtask

    task automatic test_auto_eoi;
        do_reset();
        interrupt_request = 8'h04;
`ifdef AUTO_EOI_EN
        auto_eoi_config = 1'b1;
        tick();
        run_inta("aeoi", 8'h04, 8'h04, 8'h42, 1'b0, 3'd0);
        check8("aeoi isr cleared", in_service_register, 8'h00);
`else
        tick();
        run_inta("noaeoi", 8'h04, 8'h04, 8'h42, 1'b0, 3'd0);
        check8("noaeoi isr kept", in_service_register, 8'h04);
`endif
    endtask

    task automatic test_reset_mid;
        do_reset();
        interrupt_request = 8'h04;
        tick();
        cpu_bus.interrupt_acknowledge_n = 1'b0;
        tick();
        tick();
        cpu_bus.interrupt_acknowledge_n = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        cpu_bus.interrupt_acknowledge_n = 1'b0;
        tick();
        check8("midreset isr", in_service_register, 8'h00);
        check8("midreset enable", {7'd0, cpu_bus.data_out_enable}, 8'h00);
        check8("midreset int", {7'd0, cpu_bus.interrupt}, 8'h00);
        check8("midreset clear", clear_interrupt_request, 8'h00);
        reset = 1'b0;
        cpu_bus.interrupt_acknowledge_n = 1'b1;
        tick();
        check8("midreset idle int", {7'd0, cpu_bus.interrupt}, 8'h01);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        do_reset();
        test_reset();
        test_basic();
        test_nesting();
        test_rotation();
        test_spurious();
        test_eoi();
        test_simultaneous();
        test_auto_eoi();
        test_reset_mid();
        check8("queue drained", 8'(vector_queue.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interrupt_acknowledge_sequencer.md
# interrupt_acknowledge_sequencer

Sequences the 8259A interrupt-acknowledge cycle and owns the in-service register (ISR). Resolves the pending request against the current in-service level under rotating priority and drives INT to the CPU. It then runs the two-pulse 8086-mode INTA handshake: it latches the winner, sets its ISR bit, clears its request and returns the vector byte. It sits between the interrupt request register/mask logic and the data-bus buffer, and services EOI commands from the control logic.

## Interface
- No parameters; width fixed at 8 request levels.
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- interrupt_request  in  8  masked pending requests from IRR (bit n = IRn)
- priority_rotate  in  3  lowest-priority level; highest priority is (priority_rotate+1) mod 8
- special_mask_mode  in  1  1 = ISR bits under interrupt_special_mask are ignored for nesting
- interrupt_special_mask  in  8  per-level special mask (OCW1 image)
- interrupt_acknowledge_n  in  1  INTA from CPU, active low, already synchronised
- vector_base  in  5  T7..T3 of the vector byte (ICW2)
- auto_eoi_config  in  1  ICW4 AEOI bit (present only with macro, see Configuration)
- eoi_strobe  in  1  one-cycle EOI command pulse
- eoi_specific  in  1  1 = specific EOI at eoi_level, 0 = non-specific
- eoi_level  in  3  level cleared by specific EOI
- interrupt  out  1  INT to CPU, registered
- in_service_register  out  8  ISR, registered
- highest_level_in_service  out  8  one-hot highest-priority effective ISR bit, combinational from ISR
- clear_interrupt_request  out  8  one-cycle one-hot pulse clearing the acknowledged IRR bit
- data_out  out  8  vector byte {vector_base, level}
- data_out_enable  out  1  1 while vector is driven

## Operation
- Priority: rank = (level − priority_rotate − 1) mod 8, rank 0 highest. The winning request is the lowest-rank set bit of interrupt_request.
- Effective ISR = ISR & ~interrupt_special_mask when special_mask_mode=1, else ISR. highest_level_in_service = lowest-rank set bit of effective ISR, or 0.
- An INTA falling edge is prev=1, cur=0 of a one-cycle delayed copy of interrupt_acknowledge_n; a rising edge is the reverse. Both delayed copies reset to 1.
- States:
  - IDLE: interrupt <= 1 iff a winner exists and the effective ISR is empty or the winner's rank is strictly less than the effective ISR's. On a falling edge: latch winner level, set ISR bit, pulse clear_interrupt_request, interrupt <= 0, go ACK1. With no winner the event is spurious: latch level 7, no ISR set, no clear pulse.
  - ACK1: on a rising edge go WAIT2.
  - WAIT2: on a falling edge set data_out = {vector_base, latched level}, data_out_enable <= 1, go ACK2.
  - ACK2: on a rising edge data_out_enable <= 0, go IDLE. In AEOI mode, also clear the latched ISR bit unless the event was spurious.
- interrupt is held 0 in ACK1, WAIT2 and ACK2.
- EOI (any state) on eoi_strobe: non-specific clears the highest_level_in_service bit, with no effect if zero. Specific clears ISR[eoi_level].
- Simultaneous EOI clear and acknowledge set in one cycle: clear applied first, then set. If both target the same bit, the set wins.
- data_out holds its last value when not enabled; it resets to 0x00.

## Timing
- Reset values: interrupt=0, ISR=0x00, clear_interrupt_request=0x00, data_out=0x00, data_out_enable=0, state IDLE, latched level=0.
- Reset mid-sequence aborts to IDLE with all of the above, regardless of INTA level.
- An INTA edge on the pin is detected 1 cycle later; the registered response is visible 2 cycles after the pin edge.
- interrupt reflects request and ISR changes with 1-cycle latency.
- clear_interrupt_request is high for exactly 1 cycle, in the same cycle the ISR bit becomes visible.
- A falling edge in ACK1 or ACK2, or a rising edge in IDLE or WAIT2, is ignored.

## Configuration
- AUTO_EOI_EN defined: the auto_eoi_config port exists, and AEOI clears the ISR bit on the second INTA rising edge.
- Not defined: the port is absent, ISR bits are cleared only by EOI commands, and the ACK2 exit performs no ISR update.

## Test plan
- rotate=7, IR=0x24, ISR=0 -> interrupt=1. After INTA#1: ISR=0x04, clear=0x04 for 1 cycle. After INTA#2 with vector_base=0x08: data_out=0x42.
- ISR=0x02 (IR1 in service), IR=0x08 -> interrupt stays 0. With special_mask_mode=1 and mask=0x02 -> interrupt=1.
- rotate=2, IR=0x09 -> winner is IR3: ISR=0x08, vector low bits=3.
- Request withdrawn before INTA#1 -> vector {base,3'b111}, ISR unchanged, no clear pulse.
- ISR=0x0A, non-specific EOI with rotate=7 -> ISR=0x08. Specific EOI level 3 -> ISR=0x00. With AUTO_EOI_EN and auto_eoi_config=1, the ISR bit clears after INTA#2.
- Reset asserted in WAIT2 -> next cycle state IDLE, ISR=0, data_out_enable=0, interrupt=0.
